// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and serial line levels.
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter; tick marks the last cycle of a period. Shared by the TX and RX paths.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt_r;

  // Reload on request, otherwise count toward zero and rest there.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= div;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pulls characters from the TX FIFO and serialises start/data/parity/stop.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 two_stop_i,
  input  logic                 parity_odd_i,
  input  logic                 fifo_load_i,
  input  logic [DATA_SIZE-1:0] fifo_data_i,
  output logic                 fifo_pull_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned BCW = $clog2(DATA_SIZE) + 1;
  localparam logic [BCW-1:0] BIT_ZERO = {BCW{1'b0}};
  localparam logic [BCW-1:0] BIT_ONE  = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_SIZE - 1);

  uart_state_e          state_r, state_n;
  logic [DATA_SIZE-1:0] shift_r, shift_n;
  logic [BCW-1:0]       bit_cnt_r, bit_cnt_n;
  logic                 stop_cnt_r, stop_cnt_n;
  logic [DIV_WIDTH-1:0] baud_div_r, div_n;
  logic                 two_stop_r, two_stop_n;
  logic                 tx_r, tx_n;
  logic                 busy_r, busy_n;
  logic                 capture_s;
  logic                 load_s;
  logic                 done_s;
  logic                 tick_s;
  logic                 start_ok_s;
  logic                 next_line_s;

`ifdef UART_TX_PARITY_EN
  logic parity_odd_r, odd_n;
  logic par_r, par_n;

  function automatic logic parity_of(input logic [DATA_SIZE-1:0] d);
    return ^d;
  endfunction
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_odd_i;
`endif

  assign start_ok_s = en_i & fifo_load_i;

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load   (load_s),
    .div    (div_n),
    .tick   (tick_s)
  );

  // Next-state, frame capture and period-reload decisions.
  always_comb begin
    state_n    = state_r;
    shift_n    = shift_r;
    bit_cnt_n  = bit_cnt_r;
    stop_cnt_n = stop_cnt_r;
    capture_s  = 1'b0;
    load_s     = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          capture_s = 1'b1;
          state_n   = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_n   = ST_DATA;
          bit_cnt_n = BIT_ZERO;
          load_s    = 1'b1;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          load_s  = 1'b1;
          shift_n = {1'b0, shift_r[DATA_SIZE-1:1]};
          if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
            stop_cnt_n = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt_r + BIT_ONE;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_n    = ST_STOP;
          stop_cnt_n = 1'b0;
          load_s     = 1'b1;
        end else begin
          state_n = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          if (two_stop_r && !stop_cnt_r) begin
            stop_cnt_n = 1'b1;
            load_s     = 1'b1;
          end else begin
            done_s = 1'b1;
            // Back-to-back: next start bit follows the final stop cycle directly.
            if (start_ok_s) begin
              capture_s = 1'b1;
              state_n   = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    shift_n    = capture_s ? fifo_data_i : shift_n;
    div_n      = capture_s ? baud_div_i : baud_div_r;
    two_stop_n = capture_s ? two_stop_i : two_stop_r;
    stop_cnt_n = capture_s ? 1'b0 : stop_cnt_n;
    load_s     = load_s | capture_s;
`ifdef UART_TX_PARITY_EN
    odd_n = capture_s ? parity_odd_i : parity_odd_r;
    par_n = capture_s ? parity_of(fifo_data_i) : par_r;
`endif
    busy_n = (state_n != ST_IDLE);
  end

  // Line level for the upcoming cycle, so tx_o comes straight from a flop.
  always_comb begin
    next_line_s = LINE_IDLE;
    case (state_n)
      ST_IDLE:   next_line_s = LINE_IDLE;
      ST_START:  next_line_s = LINE_START;
      ST_DATA:   next_line_s = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: next_line_s = par_n ^ odd_n;
`endif
      ST_STOP:   next_line_s = LINE_IDLE;
      default:   next_line_s = LINE_IDLE;
    endcase
    tx_n = next_line_s;
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r    <= ST_IDLE;
      shift_r    <= {DATA_SIZE{1'b0}};
      bit_cnt_r  <= BIT_ZERO;
      stop_cnt_r <= 1'b0;
      baud_div_r <= {DIV_WIDTH{1'b0}};
      two_stop_r <= 1'b0;
      tx_r       <= LINE_IDLE;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      shift_r    <= shift_n;
      bit_cnt_r  <= bit_cnt_n;
      stop_cnt_r <= stop_cnt_n;
      baud_div_r <= div_n;
      two_stop_r <= two_stop_n;
      tx_r       <= tx_n;
      busy_r     <= busy_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity configuration and data parity for the current frame.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      parity_odd_r <= 1'b0;
      par_r        <= 1'b0;
    end else begin
      parity_odd_r <= odd_n;
      par_r        <= par_n;
    end
  end
`endif

  // Pull and capture share a cycle; both strobes are held off during reset.
  assign fifo_pull_o = capture_s & rstn_i;
  assign done_o      = done_s & rstn_i;
  assign tx_o        = tx_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: FIFO model, serial-line scoreboard and directed steps.
module tb_uart_tx_serializer;

  localparam int DS = 8;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          en_i;
  logic [DW-1:0] baud_div_i;
  logic          two_stop_i;
  logic          parity_odd_i;
  logic          fifo_load_i;
  logic [DS-1:0] fifo_data_i;
  logic          fifo_pull_o;
  logic          tx_o;
  logic          busy_o;
  logic          done_o;

  uart_tx_serializer #(.DATA_SIZE(DS), .DIV_WIDTH(DW)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .baud_div_i   (baud_div_i),
    .two_stop_i   (two_stop_i),
    .parity_odd_i (parity_odd_i),
    .fifo_load_i  (fifo_load_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_pull_o  (fifo_pull_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulls = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         pull_cyc = 0;
  int         frame_len = 0;
  bit         mon_en = 1'b0;
  bit         pop_pending = 1'b0;
  logic [DS-1:0] fq[$];
  logic [1:0]    exp_q[$];
  int            pull_cyc_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_load_i = (fq.size() != 0);
    fifo_data_i = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  function automatic int exp_len(input int div, input bit two);
    int p;
`ifdef UART_TX_PARITY_EN
    p = 1;
`else
    p = 0;
`endif
    return (1 + DS + p + (two ? 2 : 1)) * (div + 1);
  endfunction

  // Expected line levels {tx, done} for one frame, one entry per clock cycle.
  task automatic push_frame(input logic [DS-1:0] d, input int div, input bit two, input bit odd);
    logic bits[$];
    logic p;
    int   total;
    int   k;
    bits.push_back(1'b0);
    p = odd;
    for (int i = 0; i < DS; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
`ifdef UART_TX_PARITY_EN
    bits.push_back(p);
`endif
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    total = bits.size() * (div + 1);
    k = 0;
    foreach (bits[b]) begin
      for (int r = 0; r <= div; r++) begin
        exp_q.push_back({bits[b], (k == total - 1) ? 1'b1 : 1'b0});
        k++;
      end
    end
  endtask

  // Line monitor: compares every cycle against the scoreboard, idle high when it is empty.
  initial begin
    logic [1:0] e;
    logic       exp_busy;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        exp_busy = (exp_q.size() != 0);
        e = exp_busy ? exp_q.pop_front() : 2'b10;
        check("tx_line", tx_o, e[1]);
        check("done_pulse", done_o, e[0]);
        check("busy", busy_o, exp_busy);
        if (!fifo_load_i) check("no_pull_empty", fifo_pull_o, 1'b0);
        if (busy_o === 1'b1) busy_cnt++;
        if (done_o === 1'b1) begin
          done_cnt++;
          frame_len = cyc - pull_cyc;
        end
        if (fifo_pull_o === 1'b1) begin
          pulls++;
          pull_cyc = cyc;
          pull_cyc_q.push_back(cyc);
          push_frame(fifo_data_i, int'(baud_div_i), two_stop_i, parity_odd_i);
          pop_pending = 1'b1;
        end
      end
    end
  end

  // FIFO head advances just after the edge that captured it.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (pop_pending) begin
        pop_pending = 1'b0;
        if (fq.size() != 0) void'(fq.pop_front());
        update_fifo();
      end
    end
  end

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk_i);
      #1;
      ok = (exp_q.size() == 0) && (busy_o === 1'b0) && !(en_i && fifo_load_i);
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_pull(input int target);
    for (int i = 0; i < 300 && pulls < target; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("wait_pull", (pulls >= target), 1'b1);
  endtask

  initial begin
    int p0;
    int d0;
    rstn_i = 1'b0;
    en_i = 1'b0;
    baud_div_i = 16'd0;
    two_stop_i = 1'b0;
    parity_odd_i = 1'b0;
    update_fifo();

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_tx", tx_o, 1'b1);
    check("rst_pull", fifo_pull_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    mon_en = 1'b1;

    // Single 0xA5 frame, 4 cycles per bit.
    baud_div_i = 16'd3;
    p0 = pulls;
    fq.push_back(8'hA5);
    update_fifo();
    en_i = 1'b1;
    wait_idle("idle_single");
    check("single_pulls", pulls, p0 + 1);
    check("single_len", frame_len, exp_len(3, 1'b0));
    check("single_len_40", frame_len, 40);

    // Three back-to-back frames at one cycle per bit.
    baud_div_i = 16'd0;
    p0 = pulls;
    pull_cyc_q.delete();
    busy_cnt = 0;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    fq.push_back(8'h55);
    update_fifo();
    wait_idle("idle_b2b");
    check("b2b_pulls", pulls, p0 + 3);
    check("b2b_pull_n", pull_cyc_q.size(), 3);
    if (pull_cyc_q.size() == 3) begin
      check("b2b_gap1", pull_cyc_q[1] - pull_cyc_q[0], exp_len(0, 1'b0));
      check("b2b_gap2", pull_cyc_q[2] - pull_cyc_q[1], 10);
    end
    check("b2b_busy", busy_cnt, 3 * exp_len(0, 1'b0));

    // Two stop bits, odd parity when compiled in.
    baud_div_i = 16'd1;
    two_stop_i = 1'b1;
    parity_odd_i = 1'b1;
    p0 = pulls;
    fq.push_back(8'h07);
    update_fifo();
    wait_idle("idle_two_stop");
    check("two_stop_pulls", pulls, p0 + 1);
`ifdef UART_TX_PARITY_EN
    check("two_stop_len", frame_len, 24);
`else
    check("two_stop_len", frame_len, 22);
`endif
    two_stop_i = 1'b0;
    parity_odd_i = 1'b0;

    // Empty FIFO with enable, then data present with enable low.
    p0 = pulls;
    repeat (50) @(posedge clk_i);
    #1;
    check("empty_pulls", pulls, p0);
    en_i = 1'b0;
    fq.push_back(8'h3C);
    update_fifo();
    repeat (20) @(posedge clk_i);
    #1;
    check("gated_pulls", pulls, p0);
    check("gated_fifo", fq.size(), 1);
    check("gated_tx", tx_o, 1'b1);
    fq.delete();
    update_fifo();

    // Enable dropped during data bit 3 of the first of two queued characters.
    baud_div_i = 16'd1;
    p0 = pulls;
    d0 = done_cnt;
    fq.push_back(8'h12);
    fq.push_back(8'h34);
    update_fifo();
    en_i = 1'b1;
    wait_pull(p0 + 1);
    repeat (8) @(posedge clk_i);
    #1;
    en_i = 1'b0;
    wait_idle("idle_en_drop");
    repeat (10) @(posedge clk_i);
    #1;
    check("en_drop_pulls", pulls, p0 + 1);
    check("en_drop_done", done_cnt, d0 + 1);
    check("en_drop_fifo", fq.size(), 1);
    fq.delete();
    update_fifo();

    // Reset during data bit 5, then the next character goes out from IDLE.
    p0 = pulls;
    d0 = done_cnt;
    fq.push_back(8'h5A);
    fq.push_back(8'hC3);
    update_fifo();
    en_i = 1'b1;
    wait_pull(p0 + 1);
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    rstn_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    #1;
    check("mid_rst_tx", tx_o, 1'b1);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_pull", fifo_pull_o, 1'b0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    wait_idle("idle_after_rst");
    check("rst_pulls", pulls, p0 + 2);
    check("rst_done", done_cnt, d0 + 1);
    check("rst_len", frame_len, exp_len(1, 1'b0));
    check("rst_fifo", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit engine on the far side of the TX FIFO. It pulls one character at a time from the AXI-side transmit FIFO and drives an asynchronous serial frame on `tx_o`: a start bit, DATA_SIZE data bits LSB-first, an optional parity bit, and one or two stop bits. A programmable bit-period counter sets the bit rate. Frames go back-to-back, with no idle gap, while the FIFO reports loaded data.

## Interface
- `DATA_SIZE`, 8, character width in bits; must match the FIFO data width
- `DIV_WIDTH`, 16, width of the bit-period divisor
- `clk_i`  in  1  system clock; all logic on the rising edge
- `rstn_i`  in  1  synchronous, active-low reset
- `en_i`  in  1  transmitter enable; gates only the start of new frames
- `baud_div_i`  in  DIV_WIDTH  bit period minus one, in clk_i cycles
- `two_stop_i`  in  1  1 selects two stop bits, 0 selects one
- `parity_odd_i`  in  1  1 selects odd parity, 0 selects even; ignored unless parity is compiled in
- `fifo_load_i`  in  1  FIFO head entry is valid (FIFO "load" status bit)
- `fifo_data_i`  in  DATA_SIZE  FIFO head data (combinational from the FIFO)
- `fifo_pull_o`  out  1  one-cycle pull strobe to the FIFO
- `tx_o`  out  1  serial line output, registered, idles high
- `busy_o`  out  1  a frame is in progress (state is not IDLE)
- `done_o`  out  1  one-cycle pulse in the last cycle of each frame

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP, encoded per the shared package.
- **IDLE:**
  - `tx_o` is 1.
  - If `en_i & fifo_load_i`:
    - assert `fifo_pull_o`;
    - capture `fifo_data_i` into the shift register;
    - latch `baud_div_i`, `two_stop_i` and `parity_odd_i` into frame registers;
    - go to START.
- **Frame settings:** configuration inputs that change mid-frame have no effect until the next frame.
- **START:** `tx_o` is 0 for one bit period, then go to DATA.
- **DATA:**
  - `tx_o` is shift register bit 0.
  - Shift right at the end of each bit period.
  - A bit counter of width clog2(DATA_SIZE)+1 counts DATA_SIZE bits.
  - Then go to PARITY when parity is compiled in, otherwise to STOP.
- **PARITY:**
  - `tx_o` is the XOR of the captured data, XORed with `parity_odd_r`.
  - Lasts one bit period, then go to STOP.
- **STOP:**
  - `tx_o` is 1 for one bit period, or two if `two_stop_r` is set.
  - In the final cycle, assert `done_o`.
  - If `en_i & fifo_load_i` in that cycle, pull, capture and go directly to START. Otherwise go to IDLE.
- **Bit period:** `baud_div_r`+1 cycles. A divisor of 0 gives 1 cycle per bit, and that is legal.
- **Period counter:**
  - counts down from `baud_div_r` to 0;
  - reloads on every state or bit transition;
  - wrap is not possible.
- **Empty FIFO:** never pull when `fifo_load_i` is 0. Data present while in IDLE with `en_i`=0 is left untouched.
- **Dropping `en_i` mid-frame:** the current frame completes and no further pull occurs.
- **Reset:** `rstn_i`=0 on any edge, including mid-frame, gives:
  - state IDLE;
  - `tx_o`=1, `fifo_pull_o`=0, `busy_o`=0, `done_o`=0;
  - shift register, counters and frame registers at 0.

## Timing
- **Reset values:** `tx_o`=1, `fifo_pull_o`=0, `busy_o`=0, `done_o`=0.
- **Start latency:**
  - Cycle T: `fifo_pull_o`=1 while in IDLE.
  - Cycle T+1: `tx_o`=0 and `busy_o`=1.
- **Frame length:** (1 + DATA_SIZE + P + S)·(`baud_div_r`+1) cycles, where P = 1 with parity and 0 without, and S = 1 or 2.
- **Back-to-back frames:** the start bit of the next frame begins in the cycle after the final stop cycle, so there is zero idle time.
- **Pull vs. capture:** `fifo_pull_o` and data capture fall in the same cycle, because the FIFO advances its head on the following edge.
- **Output glitches:** `tx_o` changes only on clock edges and never glitches.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:**
  - PARITY state exists;
  - `parity_odd_i` is honoured;
  - frames carry 1 parity bit.
- **Undefined:**
  - PARITY state, parity logic and `parity_odd_r` are removed;
  - `parity_odd_i` stays on the port but is unused;
  - DATA goes straight to STOP.

## Structure
- **Shared package `uart_pkg`:**
  - the state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, held in a 3-bit state);
  - line level constants (`LINE_IDLE`=1, `LINE_START`=0).
- **Sub-module `uart_baud_counter`:**
  - a DIV_WIDTH down-counter;
  - inputs: `load`, `div`;
  - output: a `tick` pulse at terminal count;
  - the intended RX sampler reuses it.

## Test plan
- **Single frame:**
  - Stimulus: reset, then `en_i`=1, `baud_div_i`=3, 1 stop bit, no parity, FIFO holding 0xA5.
  - Response: one pull; `tx_o` is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; `done_o` pulses at cycle 40 of the frame.
- **Back-to-back frames:**
  - Stimulus: 3 entries loaded (0x00, 0xFF, 0x55), `baud_div_i`=0.
  - Response: 3 pulls, spaced exactly 10 cycles apart; `tx_o` never idles between frames; `busy_o` stays 1 for 30 cycles.
- **Parity and two stop bits (`UART_TX_PARITY_EN` defined):**
  - Stimulus: 0x07 with odd parity, `two_stop_i`=1, `baud_div_i`=1.
  - Response: parity bit 0; frame 24 cycles; both stop bits high.
- **Empty FIFO and enable gating:**
  - Stimulus: `fifo_load_i`=0 for 50 cycles, then `fifo_load_i`=1 with `en_i`=0.
  - Response: `fifo_pull_o` stays 0 and `tx_o` stays 1 throughout.
- **Enable dropped mid-frame:**
  - Stimulus: `en_i` deasserted in DATA bit 3 of the first of 2 queued characters.
  - Response: the first frame completes normally; no second pull.
- **Reset mid-frame:**
  - Stimulus: `rstn_i`=0 during DATA bit 5.
  - Response: at the next edge `tx_o`=1, `busy_o`=0, `fifo_pull_o`=0; after release, the next frame starts cleanly from IDLE.
